// File: rtl/bus_dev_port_if.sv
// Bus-side handshake between the generator/arbiter (master) and one device port (slave).
// TX offer is pndng/D_pop consumed by pop; RX delivery is push/D_push.
interface bus_dev_port_if #(
  parameter int pckg_sz = 16
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_dev_port.sv
// Bus device endpoint: FWFT TX/RX FIFOs plus destination-ID filtering and sticky error flags.
// Latency 1 cycle write-to-visible; full FIFOs drop writes unless a same-cycle read frees a slot.
module fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  input  logic [width-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic [width-1:0]           rd_dat,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // A read from a full FIFO frees the slot the same-cycle write lands in.
  assign empty  = (count == '0);
  assign rd_ok  = rd_rdy && !empty;
  assign wr_ok  = wr_vld && ((count != cw'(depth)) || rd_ok);
  assign ovf    = wr_vld && !wr_ok;
  assign udf    = rd_rdy && empty;
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + aw'(1);
      if (rd_ok) rd_ptr <= rd_ptr + aw'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_dev_port_if.slave              bus,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic [7:0]                 drop_cnt,
  output logic [3:0]                 err_flags,
  input  logic                       err_clr
);
  localparam int cw = $clog2(depth+1);

  logic [pckg_sz-1:0] tx_head;
  logic               tx_empty;
  logic               tx_ovf;
  logic               tx_udf;
  logic               rx_ovf;
  logic               rx_udf;
  logic [7:0]         dest;
  logic               hit;
  logic               accept;
  logic [3:0]         err_ev;

  assign dest   = bus.D_push[pckg_sz-1 -: 8];
  assign hit    = (dest == id) || (dest == broadcast);
  assign accept = bus.push && hit;

  fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (tx_wr),
    .wr_dat (tx_data),
    .rd_rdy (bus.pop),
    .rd_dat (tx_head),
    .count  (tx_count),
    .empty  (tx_empty),
    .ovf    (tx_ovf),
    .udf    (tx_udf)
  );

  fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (accept),
    .wr_dat (bus.D_push),
    .rd_rdy (rx_rd),
    .rd_dat (rx_data),
    .count  (rx_count),
    .empty  (rx_empty),
    .ovf    (rx_ovf),
    .udf    (rx_udf)
  );

  assign bus.pndng = !tx_empty;
  assign bus.D_pop = tx_head;
  assign tx_full   = (tx_count == cw'(depth));
  assign err_ev    = {rx_ovf, rx_udf, tx_udf, tx_ovf};

  // Overflow of an accepted packet is an error, not a filter drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (bus.push && !hit && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // A new error in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flags <= '0;
    end else begin
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_ev;
    end
  end
endmodule

// File: tb/tb_bus_dev_port.sv
// Bench for bus_dev_port (id=3): directed scenarios plus random traffic against a queue-based model.
module tb_bus_dev_port;
  localparam int         W  = 16;
  localparam int         D  = 8;
  localparam logic [7:0] ID = 8'h03;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_wr = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_full;
  logic        rx_rd = 1'b0;
  logic [15:0] rx_data;
  logic        rx_empty;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic [7:0]  drop_cnt;
  logic [3:0]  err_flags;
  logic        err_clr = 1'b0;

  bus_dev_port_if #(.pckg_sz(W)) bus ();

  bus_dev_port #(.pckg_sz(W), .depth(D), .id(ID), .broadcast(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .rx_rd     (rx_rd),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .drop_cnt  (drop_cnt),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  int          m_drop;
  logic [3:0]  m_err;

  logic [54:0] dut_vec;
  assign dut_vec = {bus.pndng, bus.D_pop, tx_full, tx_count, rx_empty, rx_data, rx_count, drop_cnt, err_flags};

  function automatic logic [54:0] exp_vec();
    logic [15:0] th;
    logic [15:0] rh;
    th = (tx_q.size() != 0) ? tx_q[0] : 16'h0000;
    rh = (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
    return {tx_q.size() != 0, th, tx_q.size() == D, 4'(tx_q.size()),
            rx_q.size() == 0, rh, 4'(rx_q.size()), 8'(m_drop), m_err};
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_drop = 0;
    m_err  = 4'b0000;
  endtask

  // Drives one cycle of inputs, advances the model, and returns 1 time unit after the edge.
  task automatic step(input logic twr, input logic [15:0] td, input logic p,
                      input logic ps, input logic [15:0] dp, input logic rr, input logic ec);
    logic [3:0] ev;
    logic [7:0] dst;
    tx_wr = twr; tx_data = td; bus.pop = p; bus.push = ps; bus.D_push = dp;
    rx_rd = rr; err_clr = ec;
    ev = 4'b0000;
    if (p) begin
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      else ev[1] = 1'b1;
    end
    if (twr) begin
      if (tx_q.size() < D) tx_q.push_back(td);
      else ev[0] = 1'b1;
    end
    if (rr) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      else ev[2] = 1'b1;
    end
    if (ps) begin
      dst = dp[15:8];
      if (dst == ID || dst == 8'hFF) begin
        if (rx_q.size() < D) rx_q.push_back(dp);
        else ev[3] = 1'b1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    m_err = (ec ? 4'b0000 : m_err) | ev;
    @(posedge clk);
    #1;
    tx_wr = 1'b0; bus.pop = 1'b0; bus.push = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.pop = 1'b0; bus.push = 1'b0; bus.D_push = '0;
    model_reset();
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.pndng !== 1'b0 || rx_empty !== 1'b1 || tx_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got pndng=%b rx_empty=%b tx_full=%b exp 0 1 0", bus.pndng, rx_empty, tx_full);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tx_basic();
    step(1'b1, 16'h0311, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (bus.pndng !== 1'b1 || bus.D_pop !== 16'h0311) begin
      n_fail++;
      $display("FAIL tx_first got pndng=%b D_pop=%h exp 1 0311", bus.pndng, bus.D_pop);
    end
    step(1'b1, 16'h0522, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (bus.D_pop !== 16'h0522) begin
      n_fail++;
      $display("FAIL tx_second got %h exp 0522", bus.D_pop);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (bus.pndng !== 1'b0 || bus.D_pop !== 16'h0 || tx_count !== 4'd0) begin
      n_fail++;
      $display("FAIL tx_drain got pndng=%b D_pop=%h cnt=%0d exp 0 0000 0", bus.pndng, bus.D_pop, tx_count);
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < D; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (tx_full !== 1'b1 || tx_count !== 4'd8) begin
      n_fail++;
      $display("FAIL tx_fill got full=%b cnt=%0d exp 1 8", tx_full, tx_count);
    end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (err_flags !== 4'b0001 || tx_count !== 4'd8) begin
      n_fail++;
      $display("FAIL tx_ovf got err=%b cnt=%0d exp 0001 8", err_flags, tx_count);
    end
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (tx_count !== 4'd8 || bus.D_pop !== 16'h1001) begin
      n_fail++;
      $display("FAIL tx_full_wr_pop got cnt=%0d D_pop=%h exp 8 1001", tx_count, bus.D_pop);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (bus.D_pop !== 16'hBEEF || tx_count !== 4'd1) begin
      n_fail++;
      $display("FAIL tx_last_entry got D_pop=%h cnt=%0d exp BEEF 1", bus.D_pop, tx_count);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL tx_full_end got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_rx_filter();
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFBB, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h07CC, 1'b0, 1'b0);
    n_tests++;
    if (rx_count !== 4'd2 || rx_data !== 16'h03AA || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL rx_filter got cnt=%0d data=%h drop=%0d exp 2 03AA 1", rx_count, rx_data, drop_cnt);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (rx_data !== 16'hFFBB || rx_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_read got data=%h empty=%b exp FFBB 0", rx_data, rx_empty);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL rx_filter_end got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_errors();
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (err_flags !== 4'b0010 || tx_count !== 4'd0 || bus.pndng !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_udf got err=%b cnt=%0d exp 0010 0", err_flags, tx_count);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (err_flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL rx_udf got err=%b exp 0110", err_flags);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    n_tests++;
    if (err_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL err_clr got err=%b exp 0000", err_flags);
    end
    // Underflow pop alongside a write: write still lands, and the error beats the clear.
    step(1'b1, 16'h0377, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    n_tests++;
    if (err_flags !== 4'b0010 || bus.D_pop !== 16'h0377) begin
      n_fail++;
      $display("FAIL clr_vs_err got err=%b D_pop=%h exp 0010 0377", err_flags, bus.D_pop);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL errors_end got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < D; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0310 + 16'(i), 1'b0, 1'b0);
    n_tests++;
    if (rx_count !== 4'd8 || rx_data !== 16'h0310) begin
      n_fail++;
      $display("FAIL rx_fill got cnt=%0d data=%h exp 8 0310", rx_count, rx_data);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0301, 1'b0, 1'b0);
    n_tests++;
    if (err_flags[3] !== 1'b1 || rx_count !== 4'd8 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL rx_ovf got err=%b cnt=%0d drop=%0d exp 1xxx 8 1", err_flags, rx_count, drop_cnt);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h03EE, 1'b1, 1'b0);
    n_tests++;
    if (rx_count !== 4'd8 || rx_data !== 16'h0311) begin
      n_fail++;
      $display("FAIL rx_full_push_rd got cnt=%0d data=%h exp 8 0311", rx_count, rx_data);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_tests++;
    if (rx_data !== 16'h03EE || rx_count !== 4'd1) begin
      n_fail++;
      $display("FAIL rx_tail got data=%h cnt=%0d exp 03EE 1", rx_data, rx_count);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL rx_full_end got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic        twr, p, ps, rr, ec;
    logic [15:0] td, dp;
    logic [7:0]  dst;
    for (int i = 0; i < 600; i++) begin
      // Alternate fill-biased and drain-biased phases so both FIFOs hit full and empty.
      if ((i / 60) % 2 == 0) begin
        twr = ($urandom_range(0, 3) != 0); p  = ($urandom_range(0, 3) == 0);
        ps  = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 3) == 0);
      end else begin
        twr = ($urandom_range(0, 3) == 0); p  = ($urandom_range(0, 3) != 0);
        ps  = ($urandom_range(0, 3) == 0); rr = ($urandom_range(0, 3) != 0);
      end
      ec = ($urandom_range(0, 15) == 0);
      td = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    dst = ID;
        2:       dst = 8'hFF;
        default: dst = 8'($urandom);
      endcase
      dp = {dst, 8'($urandom)};
      step(twr, td, p, ps, dp, rr, ec);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_drop_sat();
    for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0700 + 16'(i % 256), 1'b0, 1'b0);
    n_tests++;
    if (drop_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_sat got %0d exp 255", drop_cnt);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL drop_sat_state got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1, 16'h00A1, 1'b0, 1'b1, 16'h0341, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b1, 16'hFF42, 1'b0, 1'b0);
    step(1'b1, 16'h00A3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (tx_count !== 4'd3 || rx_count !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset got tx=%0d rx=%0d exp 3 2", tx_count, rx_count);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.pndng !== 1'b0 || rx_empty !== 1'b1 || bus.D_pop !== 16'h0 || rx_data !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset got pndng=%b rx_empty=%b D_pop=%h rx_data=%h exp 0 1 0 0",
               bus.pndng, rx_empty, bus.D_pop, rx_data);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset_state got %h exp %h", dut_vec, exp_vec());
    end
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_tests++;
    if (bus.pndng !== 1'b0 || rx_empty !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL post_reset got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_filter();
    test_errors();
    test_rx_full();
    test_random();
    test_drop_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
- Device-side endpoint for the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per driver slot.
- Presents outgoing packets to the bus through the pndng/pop/D_pop handshake.
- Accepts incoming packets from the bus through the push/D_push handshake.
- Buffers both directions in FWFT FIFOs behind a simple local write/read interface, and filters received packets by destination ID.

Parameters:
pckg_sz, 16, packet width in bits; destination ID = D[pckg_sz-1 -: 8]
depth, 8, entries per FIFO; power of two, >= 2
id, 0, this device's 8-bit bus ID
broadcast, 8'hFF, ID accepted by every device

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pndng  out  1  TX FIFO non-empty, to bus
D_pop  out  pckg_sz  TX FIFO head, to bus
pop  in  1  bus consumes TX head this cycle
push  in  1  bus delivers D_push this cycle
D_push  in  pckg_sz  packet from bus
tx_wr  in  1  local write into TX FIFO
tx_data  in  pckg_sz  local TX data
tx_full  out  1  TX FIFO full
rx_rd  in  1  local read (advance) of RX FIFO
rx_data  out  pckg_sz  RX FIFO head (FWFT)
rx_empty  out  1  RX FIFO empty
tx_count  out  $clog2(depth+1)  TX occupancy
rx_count  out  $clog2(depth+1)  RX occupancy
drop_cnt  out  8  packets rejected by ID filter, saturating
err_flags  out  4  sticky {rx_ovf, rx_udf, tx_udf, tx_ovf}
err_clr  in  1  synchronous clear of err_flags

Behaviour:
Reset (reset=0, async):
- Pointers and counts go to 0; FIFO contents are discarded.
- pndng=0, tx_full=0, rx_empty=1, D_pop=0, rx_data=0, drop_cnt=0, err_flags=0.
- Reset asserted mid-operation has the same effect: any in-flight packet is lost, no partial state is kept.
- All state otherwise updates on the rising clk edge.

TX FIFO:
- pndng = (tx_count != 0), combinational from state.
- D_pop = head entry when pndng=1, else 0.
- tx_wr with tx_full=0: tx_data is written; pndng rises the cycle after the edge (1-cycle latency).
- tx_wr with tx_full=1 and pop=0: write is dropped; tx_ovf sets.
- tx_wr with tx_full=1 and pop=1: both happen; count unchanged.
- pop with pndng=1: head advances; D_pop shows the next entry, or 0 if the FIFO is now empty.
- pop with pndng=0: ignored; tx_udf sets. A same-cycle tx_wr still succeeds.
- Pointers wrap modulo depth.
- tx_full = (tx_count == depth).

RX path:
- On push=1, dest = D_push[pckg_sz-1 -: 8].
- Packet is accepted iff dest == id or dest == broadcast.
- Rejected packet: drop_cnt increments, saturating at 255; FIFO untouched.
- Accepted packet with RX not full: stored; rx_empty falls the next cycle.
- Accepted packet with RX full and rx_rd=0: dropped; rx_ovf sets. drop_cnt does not count overflow.
- Accepted packet with RX full and rx_rd=1: both happen; count unchanged.
- rx_data = head entry when non-empty, else 0.
- rx_rd with rx_empty=1: ignored; rx_udf sets. A same-cycle push is still stored.

err_flags:
- Each bit is sticky until err_clr=1.
- If err_clr coincides with a new error event, the error wins and the bit stays 1.

Independence and concurrency:
- TX and RX paths are fully independent; all four handshakes may be active in the same cycle.
- No combinational path from any input to any output except through state.
- Exception: pndng, D_pop, rx_data, and the flags are decoded from registered state only.

Test Plan:
- Reset with id=3: tx_wr of 16'h0311, 16'h0522 -> pndng=1 next cycle, D_pop=16'h0311; pop -> D_pop=16'h0522; pop -> pndng=0, D_pop=0, tx_count=0.
- Fill TX with 8 writes -> tx_full=1; 9th tx_wr -> dropped, err_flags[0]=1. Same state with tx_wr+pop together -> tx_count stays 8, new data becomes the last entry.
- id=3: push D_push=16'h03AA, then 16'hFFBB, then 16'h07CC -> rx_count=2, rx_data=16'h03AA, drop_cnt=1. rx_rd -> rx_data=16'hFFBB.
- pop with TX empty -> err_flags[1]=1, no pointer change. rx_rd with RX empty -> err_flags[2]=1. err_clr -> err_flags=0.
- Fill RX to 8, then push 16'h0301 -> err_flags[3]=1, rx_count=8. Push + rx_rd same cycle -> count 8, oldest entry replaced at tail.
- With TX holding 3 and RX holding 2 entries, assert reset=0 mid-cycle -> outputs go to reset values immediately, before the next clk edge; after release, pndng=0 and rx_empty=1.
